// File: rtl/shiftreg_pkg.sv
// Shared definitions for the 4-bit shift register and its serial word collector.
// Line levels and the default word width live here so both ends of the link agree.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_LVL      = 1'b1;
    localparam logic STOP_LVL       = 1'b0;
    localparam int   DEFAULT_WORD_W = 4;

endpackage

// File: rtl/serial_word_collector.sv
// Reassembles start/data/parity/stop frames sampled from the shift register's
// serial output on each SHIFT_EN strobe and emits the word with error pulses.
module serial_word_collector
    import shiftreg_pkg::*;
#(
    parameter int WORD_W    = DEFAULT_WORD_W,
    parameter int PARITY_EN = 1,
    parameter int CNT_W     = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SHIFT_EN,
    input  logic              SER_IN,
    output logic [WORD_W-1:0] WORD_OUT,
    output logic              WORD_VALID,
    output logic              PARITY_ERR,
    output logic              FRAME_ERR,
    output logic              BUSY
);

    state_t            r_state;
    logic [WORD_W-1:0] r_buf;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_par;
    logic              r_parOk;
    logic [WORD_W-1:0] r_wordOut;
    logic              r_valid;
    logic              r_parErr;
    logic              r_frameErr;

    state_t            w_stateNext;
    logic [WORD_W-1:0] w_bufNext;
    logic [CNT_W-1:0]  w_cntNext;
    logic              w_parNext;
    logic              w_parOkNext;
    logic [WORD_W-1:0] w_wordNext;
    logic              w_validNext;
    logic              w_parErrNext;
    logic              w_frameErrNext;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_par      <= 1'b0;
            r_parOk    <= 1'b0;
            r_wordOut  <= '0;
            r_valid    <= 1'b0;
            r_parErr   <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_buf      <= w_bufNext;
            r_cnt      <= w_cntNext;
            r_par      <= w_parNext;
            r_parOk    <= w_parOkNext;
            r_wordOut  <= w_wordNext;
            r_valid    <= w_validNext;
            r_parErr   <= w_parErrNext;
            r_frameErr <= w_frameErrNext;
        end
    end

    // Everything holds between strobes; only the output pulses fall back to 0.
    always_comb begin
        w_stateNext    = r_state;
        w_bufNext      = r_buf;
        w_cntNext      = r_cnt;
        w_parNext      = r_par;
        w_parOkNext    = r_parOk;
        w_wordNext     = r_wordOut;
        w_validNext    = 1'b0;
        w_parErrNext   = 1'b0;
        w_frameErrNext = 1'b0;

        if (SHIFT_EN) begin
            unique case (r_state)
                IDLE: begin
                    if (SER_IN == START_LVL) begin
                        w_stateNext = DATA;
                        w_cntNext   = '0;
                        w_parNext   = 1'b0;
                        w_parOkNext = 1'b1;
                    end
                end
                DATA: begin
                    // Bits arrive LSB first, so entering at the MSB leaves bit 0 at the bottom.
                    w_bufNext = {SER_IN, r_buf[WORD_W-1:1]};
                    w_parNext = r_par ^ SER_IN;
                    w_cntNext = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WORD_W - 1)) begin
                        w_stateNext = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    w_parOkNext = ~(r_par ^ SER_IN);
                    w_stateNext = STOP;
                end
                STOP: begin
                    if (SER_IN == STOP_LVL) begin
                        w_wordNext   = r_buf;
                        w_validNext  = 1'b1;
                        w_parErrNext = ~r_parOk;
                    end else begin
                        w_frameErrNext = 1'b1;
                    end
                    w_stateNext = IDLE;
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    assign WORD_OUT   = r_wordOut;
    assign WORD_VALID = r_valid;
    assign PARITY_ERR = r_parErr;
    assign FRAME_ERR  = r_frameErr;
    assign BUSY       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_word_collector.sv
// Randomised and directed bench for serial_word_collector, checked against a
// frame-level model that buffers sampled bits and judges each complete frame.
module tb_serial_word_collector;

    localparam int WORD_W    = 4;
    localparam int PARITY_EN = 1;
    localparam int FRAME_LEN = 1 + WORD_W + PARITY_EN + 1;

    logic              CLK;
    logic              RESET;
    logic              SHIFT_EN;
    logic              SER_IN;
    logic [WORD_W-1:0] WORD_OUT;
    logic              WORD_VALID;
    logic              PARITY_ERR;
    logic              FRAME_ERR;
    logic              BUSY;

    int checkCount;
    int failCount;
    int cycleCnt;
    int validCycles[$];

    bit              frameBits[$];
    logic [WORD_W-1:0] expWord;
    logic            expValid;
    logic            expParErr;
    logic            expFrameErr;

    serial_word_collector #(
        .WORD_W   (WORD_W),
        .PARITY_EN(PARITY_EN),
        .CNT_W    (3)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SHIFT_EN  (SHIFT_EN),
        .SER_IN    (SER_IN),
        .WORD_OUT  (WORD_OUT),
        .WORD_VALID(WORD_VALID),
        .PARITY_ERR(PARITY_ERR),
        .FRAME_ERR (FRAME_ERR),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".word"},  32'(WORD_OUT),   32'(expWord));
        checkOutput({tag, ".valid"}, 32'(WORD_VALID), 32'(expValid));
        checkOutput({tag, ".perr"},  32'(PARITY_ERR), 32'(expParErr));
        checkOutput({tag, ".ferr"},  32'(FRAME_ERR),  32'(expFrameErr));
        checkOutput({tag, ".busy"},  32'(BUSY),       32'(frameBits.size() != 0));
    endtask

    // Frame-level model: collect bits from a start bit until a whole frame is held, then judge it.
    task automatic modelStrobe(input bit b);
        int ones;
        logic [WORD_W-1:0] data;
        if (frameBits.size() == 0) begin
            if (b) frameBits.push_back(b);
            return;
        end
        frameBits.push_back(b);
        if (frameBits.size() == FRAME_LEN) begin
            data = '0;
            ones = 0;
            for (int i = 0; i < WORD_W; i++) begin
                if (frameBits[1 + i]) data = data + (WORD_W'(1) << i);
            end
            for (int i = 1; i < 1 + WORD_W + PARITY_EN; i++) ones += int'(frameBits[i]);
            if (frameBits[FRAME_LEN - 1] == 1'b0) begin
                expWord   = data;
                expValid  = 1'b1;
                expParErr = (PARITY_EN != 0) && (ones % 2 != 0);
            end else begin
                expFrameErr = 1'b1;
            end
            frameBits.delete();
        end
    endtask

    // One clock: drive inputs, let the edge happen, update the model, compare.
    task automatic applyStimulus(input bit en, input bit b, input string tag);
        SHIFT_EN = en;
        SER_IN   = b;
        @(posedge CLK);
        #1;
        cycleCnt++;
        expValid    = 1'b0;
        expParErr   = 1'b0;
        expFrameErr = 1'b0;
        if (en) modelStrobe(b);
        if (WORD_VALID === 1'b1) validCycles.push_back(cycleCnt);
        checkAll(tag);
        SHIFT_EN = 1'b0;
    endtask

    task automatic applyReset(input string tag);
        RESET = 1'b1;
        #1;
        frameBits.delete();
        expWord     = '0;
        expValid    = 1'b0;
        expParErr   = 1'b0;
        expFrameErr = 1'b0;
        checkAll(tag);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic sendFrame(input logic [WORD_W-1:0] w, input bit badPar, input bit badStop,
                             input int gapMax, input string tag);
        bit bits[$];
        bits.push_back(1'b1);
        for (int i = 0; i < WORD_W; i++) bits.push_back(w[i]);
        if (PARITY_EN != 0) bits.push_back((^w) ^ badPar);
        bits.push_back(badStop);
        foreach (bits[i]) begin
            int gap;
            gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'($urandom), tag);
            applyStimulus(1'b1, bits[i], tag);
        end
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        cycleCnt   = 0;
        RESET      = 1'b1;
        SHIFT_EN   = 1'b0;
        SER_IN     = 1'b0;
        expWord    = '0;
        expValid   = 1'b0;
        expParErr  = 1'b0;
        expFrameErr = 1'b0;
        @(posedge CLK);
        #1;
        applyReset("reset");

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, "idle");
        checkOutput("idleWord", 32'(WORD_OUT), 32'h0);

        sendFrame(4'hB, 1'b0, 1'b0, 0, "good");
        checkOutput("goodWord", 32'(WORD_OUT), 32'hB);
        applyStimulus(1'b0, 1'b0, "goodAfter");

        sendFrame(4'hB, 1'b1, 1'b0, 0, "perr");
        checkOutput("perrFlag", 32'(PARITY_ERR), 32'h1);
        applyStimulus(1'b0, 1'b0, "perrAfter");

        sendFrame(4'h5, 1'b0, 1'b1, 0, "ferr");
        checkOutput("ferrFlag", 32'(FRAME_ERR), 32'h1);
        checkOutput("ferrKeep", 32'(WORD_OUT), 32'hB);
        applyStimulus(1'b0, 1'b0, "ferrAfter");

        validCycles.delete();
        sendFrame(4'h3, 1'b0, 1'b0, 0, "b2b");
        sendFrame(4'hC, 1'b0, 1'b0, 0, "b2b");
        applyStimulus(1'b1, 1'b0, "b2bTail");
        checkOutput("b2bCount", 32'(validCycles.size()), 32'd2);
        if (validCycles.size() >= 2)
            checkOutput("b2bGap", 32'(validCycles[1] - validCycles[0]), 32'd7);
        checkOutput("b2bWord", 32'(WORD_OUT), 32'hC);

        applyStimulus(1'b1, 1'b1, "abort");
        applyStimulus(1'b1, 1'b1, "abort");
        applyStimulus(1'b1, 1'b0, "abort");
        applyReset("midReset");
        sendFrame(4'h6, 1'b0, 1'b0, 0, "afterReset");
        checkOutput("afterResetWord", 32'(WORD_OUT), 32'h6);

        for (int n = 0; n < 150; n++) begin
            int pick;
            pick = int'($urandom_range(0, 19));
            if (pick == 0) begin
                applyReset("rndReset");
            end else if (pick < 4) begin
                applyStimulus(1'($urandom), 1'($urandom), "rndNoise");
            end else begin
                sendFrame(WORD_W'($urandom), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)), "rndFrame");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
